alu64bit_seq_responder: RTL and testbench

//  Sequential 64-bit ALU service. It accepts operation requests from an initiator
//  (sequencer or self-test driver) over a valid/ready port and returns results

---
 rtl/alu64bit_seq_responder.sv | 131 +++++++++++++
 tb/tb_alu64bit_seq_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu64bit_seq_responder.sv
// Sequential 64-bit NOR/XOR/ADD/SUB service that iterates one SLICE_W-bit slice per cycle.
// Optional feature macro ALU_SEQ_OVF_EN adds the registered signed-overflow output rsp_ovf.
module alu64bit_seq_responder #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic        req_cin,
  input  logic [1:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_s,
  output logic        rsp_cout
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic        rsp_ovf
`endif
);

  localparam int NSLICE = 64 / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (SLICE_W != 1 && SLICE_W != 2 && SLICE_W != 4 && SLICE_W != 8 &&
      SLICE_W != 16 && SLICE_W != 32 && SLICE_W != 64) begin : g_bad_slice_w
    $error("alu64bit_seq_responder: SLICE_W must be 1, 2, 4, 8, 16, 32 or 64");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OP_NOR = 2'b00, OP_XOR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;

  state_t             state;
  op_t                op_q;
  logic [63:0]        a_q;
  logic [63:0]        b_q;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic [5:0]         base;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] b_eff;
  logic [SLICE_W-1:0] slice_s;
  logic [SLICE_W:0]   slice_sum;
  logic               arith;
  logic               last;

  assign req_ready = (state == IDLE);

  // One slice of the datapath; SUB reuses the adder with b inverted.
  always_comb begin
    base      = 6'(cnt) * 6'(SLICE_W);
    a_sl      = a_q[base +: SLICE_W];
    b_sl      = b_q[base +: SLICE_W];
    arith     = op_q[1];
    b_eff     = (op_q == OP_SUB) ? ~b_sl : b_sl;
    slice_sum = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, carry};
    last      = (cnt == CNT_W'(NSLICE - 1));
    case (op_q)
      OP_NOR:  slice_s = ~(a_sl | b_sl);
      OP_XOR:  slice_s = a_sl ^ b_sl;
      default: slice_s = slice_sum[SLICE_W-1:0];
    endcase
  end

`ifdef ALU_SEQ_OVF_EN
  logic b63_eff;
  logic ovf_next;

  // Only meaningful on the last slice, where slice_s holds bit 63 of the result.
  always_comb begin
    b63_eff  = (op_q == OP_SUB) ? ~b_q[63] : b_q[63];
    ovf_next = arith && (a_q[63] == b63_eff) && (slice_s[SLICE_W-1] != a_q[63]);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_NOR;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      rsp_s     <= '0;
      rsp_cout  <= 1'b0;
      rsp_valid <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q   <= req_a;
            b_q   <= req_b;
            op_q  <= op_t'(req_op);
            carry <= req_op[1] & req_cin;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          rsp_s[base +: SLICE_W] <= slice_s;
          carry <= arith & slice_sum[SLICE_W];
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            cnt       <= '0;
            rsp_cout  <= arith & slice_sum[SLICE_W];
            rsp_valid <= 1'b1;
            state     <= DONE;
`ifdef ALU_SEQ_OVF_EN
            rsp_ovf   <= ovf_next;
`endif
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu64bit_seq_responder.sv
// Scoreboard bench for alu64bit_seq_responder (SLICE_W=16); checks rsp_ovf when ALU_SEQ_OVF_EN is defined.
module tb_alu64bit_seq_responder;

  localparam int NSLICE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        req_cin = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_s;
  logic        rsp_cout;
  logic        rsp_ovf;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    int          accept_edge;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic bp_hold = 1'b0;
  logic prev_valid = 1'b0;

  alu64bit_seq_responder #(.SLICE_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
`ifdef ALU_SEQ_OVF_EN
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
`else
    .rsp_cout  (rsp_cout)
`endif
  );

`ifndef ALU_SEQ_OVF_EN
  assign rsp_ovf = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Whole-word reference: 65-bit sum, no slicing.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic [1:0] op);
    exp_t        e;
    logic [63:0] bb;
    logic [64:0] wide;
    bb   = (op == 2'b11) ? ~b : b;
    wide = {1'b0, a} + {1'b0, bb} + 65'(cin);
    e.accept_edge = 0;
    case (op)
      2'b00: begin e.s = ~(a | b); e.cout = 1'b0; e.ovf = 1'b0; end
      2'b01: begin e.s = a ^ b;    e.cout = 1'b0; e.ovf = 1'b0; end
      default: begin
        e.s    = wide[63:0];
        e.cout = wide[64];
        e.ovf  = (a[63] == bb[63]) && (wide[63] != a[63]);
      end
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=timeout required=event", name);
  endtask

  // Issues one request at a negedge and pushes its expected response once the accept edge is known.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic cin,
                               input logic [1:0] op, output int waits);
    exp_t e;
    waits = 0;
    @(negedge clk);
    req_a = a; req_b = b; req_cin = cin; req_op = op; req_valid = 1'b1;
    while (!req_ready) begin
      waits++;
      if (waits > 200) begin
        failNow("req_accept");
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e = model(a, b, cin, op);
    e.accept_edge = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) failNow("drain");
  endtask

  // Monitor: drives rsp_ready (unless held), checks latency on rise and data on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (!bp_hold) rsp_ready = ($urandom_range(0, 3) != 0);
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rsp actual=%h required=none", rsp_s);
        end else begin
          checkOutput("latency", 64'(cyc - sb[0].accept_edge), 64'(NSLICE));
        end
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("rsp_s", rsp_s, e.s);
        checkOutput("rsp_cout", 64'(rsp_cout), 64'(e.cout));
`ifdef ALU_SEQ_OVF_EN
        checkOutput("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
`endif
      end
      prev_valid = rsp_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   waits;
    int   n;
    exp_t e1;
    logic [63:0] ra, rb;
    logic [63:0] corner [4];

    corner[0] = 64'h0;
    corner[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    corner[2] = 64'h8000_0000_0000_0000;
    corner[3] = 64'h7FFF_FFFF_FFFF_FFFF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rsp_s", rsp_s, 64'd0);
    checkOutput("reset_rsp_cout", 64'(rsp_cout), 64'd0);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);

    // Reset mid-BUSY: operation dropped, no response expected.
    @(negedge clk);
    req_a = 64'd1234; req_b = 64'd5; req_cin = 1'b0; req_op = 2'b10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midbusy_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midbusy_rst_rsp_s", rsp_s, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 checkOutput("midbusy_rst_req_ready", 64'(req_ready), 64'd1);
    repeat (NSLICE + 4) @(negedge clk);
    checkOutput("dropped_no_rsp", 64'(rsp_valid), 64'd0);

    // Directed operations.
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b10, waits);
    applyStimulus(64'd5, 64'd7, 1'b1, 2'b11, waits);
    applyStimulus(64'd7, 64'd5, 1'b1, 2'b11, waits);
    applyStimulus(64'd0, 64'hFFFF_0000_FFFF_0000, 1'b0, 2'b00, waits);
    applyStimulus(64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b01, waits);
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b10, waits);
    applyStimulus(64'h8000_0000_0000_0000, 64'd1, 1'b1, 2'b11, waits);
    waitDrain();

    // Backpressure in DONE with a request waiting.
    @(posedge clk);
    #1 bp_hold = 1'b1; rsp_ready = 1'b0;
    e1 = model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 2'b10);
    applyStimulus(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 2'b10, waits);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) failNow("bp_wait_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_a = 64'h1111_2222_3333_4444; req_b = 64'h0000_0000_0000_00FF;
      req_cin = 1'b0; req_op = 2'b01; req_valid = 1'b1;
      checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("bp_rsp_s", rsp_s, e1.s);
      checkOutput("bp_rsp_cout", 64'(rsp_cout), 64'(e1.cout));
      checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("bp_release_req_ready", 64'(req_ready), 64'd1);
    applyStimulus(64'h1111_2222_3333_4444, 64'h0000_0000_0000_00FF, 1'b0, 2'b01, waits);
    checkOutput("bp_queued_accept_waits", 64'(waits), 64'd0);
    bp_hold = 1'b0;
    waitDrain();

    // Randomized operations with occasional corner operands.
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = corner[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) rb = corner[$urandom_range(0, 3)];
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), waits);
    end
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
